// File: rtl/bcd_counter_multi.sv
// Multi-digit packed-BCD up/down counter with programmable modulus and carry/borrow pulses.
// Parallel load with range checking is built only when BCD_LOAD_EN is defined.
module bcd_counter_multi #(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  carry,
    output logic                  borrow,
    output logic                  tc,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] r;
        int           v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] x);
        logic [W-1:0] r;
        logic         c;
        r = x;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (x[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = x[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] x);
        logic [W-1:0] r;
        logic         b;
        r = x;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (x[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = x[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [W-1:0] cnt_q, cnt_nxt;
    logic         carry_q, carry_nxt;
    logic         borrow_q, borrow_nxt;
    logic         rst_rel_q;

`ifdef BCD_LOAD_EN
    // With every digit <= 9, packed BCD orders the same as the decimal value.
    function automatic logic load_ok(input logic [W-1:0] x);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (x[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok && (x <= MAX_BCD);
    endfunction

    logic err_q, err_nxt;
`endif

    always_comb begin
        cnt_nxt    = cnt_q;
        carry_nxt  = 1'b0;
        borrow_nxt = 1'b0;
`ifdef BCD_LOAD_EN
        err_nxt    = 1'b0;
`endif
        if (clr) begin
            cnt_nxt = '0;
        end
`ifdef BCD_LOAD_EN
        else if (load) begin
            if (load_ok(load_val)) cnt_nxt = load_val;
            else                   err_nxt = 1'b1;
        end
`endif
        else if (en) begin
            if (up) begin
                if (cnt_q == MAX_BCD) begin
                    cnt_nxt   = '0;
                    carry_nxt = 1'b1;
                end else begin
                    cnt_nxt = bcd_inc(cnt_q);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_nxt    = MAX_BCD;
                    borrow_nxt = 1'b1;
                end else begin
                    cnt_nxt = bcd_dec(cnt_q);
                end
            end
        end
    end

    // Reset asserts immediately; the counter resumes one edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_rel_q <= 1'b0;
        else        rst_rel_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else if (!rst_rel_q) begin
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_nxt;
            carry_q  <= carry_nxt;
            borrow_q <= borrow_nxt;
        end
    end

`ifdef BCD_LOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          err_q <= 1'b0;
        else if (!rst_rel_q) err_q <= 1'b0;
        else                 err_q <= err_nxt;
    end

    assign load_err = err_q;
`else
    logic unused_load;
    assign unused_load = &{1'b0, load, load_val};
    assign load_err    = 1'b0;
`endif

    assign bcd_out = cnt_q;
    assign carry   = carry_q;
    assign borrow  = borrow_q;
    assign tc      = up ? (cnt_q == MAX_BCD) : (cnt_q == '0);

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Directed bench for bcd_counter_multi: 2-digit mod-60 core, a 4-digit mod-10000 instance,
// and a 1-digit -> 2-digit cascade. Load checks depend on BCD_LOAD_EN.
module tb_bcd_counter_multi;

    logic       clk;
    logic       rst_n;
    logic       en, clr, up, load;
    logic [7:0] load_val;
    logic [7:0] bcd_out;
    logic       carry, borrow, tc, load_err;

    logic        en4;
    logic [15:0] load_val4;
    logic [15:0] d4_out;
    logic        carry4, borrow4, tc4, err4;

    logic       en_c, one_up, no_load;
    logic [3:0] load_val_lo;
    logic [7:0] load_val_hi;
    logic [3:0] lo_out;
    logic [7:0] hi_out;
    logic       lo_carry, lo_borrow, lo_tc, lo_err;
    logic       hi_carry, hi_borrow, hi_tc, hi_err;

    int vecs;
    int errs;

    bcd_counter_multi #(.DIGITS(2), .MODULUS(60)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .up(up), .load(load),
        .load_val(load_val), .bcd_out(bcd_out), .carry(carry), .borrow(borrow),
        .tc(tc), .load_err(load_err)
    );

    bcd_counter_multi #(.DIGITS(4), .MODULUS(10000)) u_d4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .clr(clr), .up(one_up), .load(no_load),
        .load_val(load_val4), .bcd_out(d4_out), .carry(carry4), .borrow(borrow4),
        .tc(tc4), .load_err(err4)
    );

    bcd_counter_multi #(.DIGITS(1), .MODULUS(10)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(en_c), .clr(clr), .up(one_up), .load(no_load),
        .load_val(load_val_lo), .bcd_out(lo_out), .carry(lo_carry), .borrow(lo_borrow),
        .tc(lo_tc), .load_err(lo_err)
    );

    bcd_counter_multi #(.DIGITS(2), .MODULUS(60)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(lo_carry), .clr(clr), .up(one_up), .load(no_load),
        .load_val(load_val_hi), .bcd_out(hi_out), .carry(hi_carry), .borrow(hi_borrow),
        .tc(hi_tc), .load_err(hi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vecs++;
        if (bcd_out !== 8'h00 || carry !== 1'b0 || borrow !== 1'b0 || load_err !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: got bcd=%h c=%b b=%b e=%b, want 00 0 0 0",
                     bcd_out, carry, borrow, load_err);
        end
        vecs++;
        if (tc !== 1'b0) begin
            errs++;
            $display("FAIL reset_tc_up: got %b, want 0", tc);
        end
        #1 rst_n = 1'b1;
        tick();
        tick();
        vecs++;
        if (bcd_out !== 8'h00) begin
            errs++;
            $display("FAIL reset_release_hold: got %h, want 00", bcd_out);
        end
    endtask

    task automatic test_count_up();
        logic [7:0] exp;
        int         carries;
        carries = 0;
        up = 1'b1;
        en = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            exp = 8'(((i % 60) / 10) * 16 + (i % 60) % 10);
            if (carry === 1'b1) carries++;
            vecs++;
            if (bcd_out !== exp || carry !== (i == 60) || borrow !== 1'b0) begin
                errs++;
                $display("FAIL count_up step %0d: got %h c=%b b=%b, want %h c=%b b=0",
                         i, bcd_out, carry, borrow, exp, (i == 60));
            end
            if (i == 59) begin
                vecs++;
                if (tc !== 1'b1) begin
                    errs++;
                    $display("FAIL tc_at_59: got %b, want 1", tc);
                end
            end
        end
        en = 1'b0;
        vecs++;
        if (carries != 1) begin
            errs++;
            $display("FAIL carry_count: got %0d, want 1", carries);
        end
        tick();
        vecs++;
        if (bcd_out !== 8'h00 || carry !== 1'b0) begin
            errs++;
            $display("FAIL hold_after_wrap: got %h c=%b, want 00 c=0", bcd_out, carry);
        end
    endtask

    task automatic test_ripple();
        do_clear();
        up = 1'b1;
        en = 1'b1;
        repeat (9) tick();
        vecs++;
        if (bcd_out !== 8'h09) begin
            errs++;
            $display("FAIL ripple_pre: got %h, want 09", bcd_out);
        end
        tick();
        vecs++;
        if (bcd_out !== 8'h10 || carry !== 1'b0 || borrow !== 1'b0) begin
            errs++;
            $display("FAIL ripple_up: got %h c=%b b=%b, want 10 0 0", bcd_out, carry, borrow);
        end
        up = 1'b0;
        tick();
        vecs++;
        if (bcd_out !== 8'h09 || carry !== 1'b0 || borrow !== 1'b0) begin
            errs++;
            $display("FAIL ripple_down: got %h c=%b b=%b, want 09 0 0", bcd_out, carry, borrow);
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
        do_clear();
        up = 1'b0;
        vecs++;
        if (tc !== 1'b1) begin
            errs++;
            $display("FAIL tc_down_zero: got %b, want 1", tc);
        end
        en = 1'b1;
        tick();
        vecs++;
        if (bcd_out !== 8'h59 || borrow !== 1'b1 || carry !== 1'b0) begin
            errs++;
            $display("FAIL down_wrap: got %h b=%b c=%b, want 59 1 0", bcd_out, borrow, carry);
        end
        tick();
        vecs++;
        if (bcd_out !== 8'h58 || borrow !== 1'b0) begin
            errs++;
            $display("FAIL down_after_wrap: got %h b=%b, want 58 0", bcd_out, borrow);
        end
        // Direction flips every cycle: 58 -> 59 -> 58
        up = 1'b1;
        tick();
        up = 1'b0;
        tick();
        vecs++;
        if (bcd_out !== 8'h58 || carry !== 1'b0 || borrow !== 1'b0) begin
            errs++;
            $display("FAIL up_toggle: got %h c=%b b=%b, want 58 0 0", bcd_out, carry, borrow);
        end
        en = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_clear();
        up = 1'b1;
        en = 1'b1;
        repeat (59) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vecs++;
        if (bcd_out !== 8'h00 || carry !== 1'b0) begin
            errs++;
            $display("FAIL clr_beats_wrap: got %h c=%b, want 00 0", bcd_out, carry);
        end
        repeat (37) tick();
        vecs++;
        if (bcd_out !== 8'h37) begin
            errs++;
            $display("FAIL pre_async_reset: got %h, want 37", bcd_out);
        end
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if (bcd_out !== 8'h00 || carry !== 1'b0 || borrow !== 1'b0 || load_err !== 1'b0) begin
            errs++;
            $display("FAIL async_reset: got %h c=%b b=%b e=%b, want 00 0 0 0",
                     bcd_out, carry, borrow, load_err);
        end
        en = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_load();
        do_clear();
`ifdef BCD_LOAD_EN
        load = 1'b1;
        load_val = 8'h45;
        tick();
        vecs++;
        if (bcd_out !== 8'h45 || load_err !== 1'b0) begin
            errs++;
            $display("FAIL load_45: got %h e=%b, want 45 0", bcd_out, load_err);
        end
        load_val = 8'h4A;
        tick();
        vecs++;
        if (bcd_out !== 8'h45 || load_err !== 1'b1) begin
            errs++;
            $display("FAIL load_4A: got %h e=%b, want 45 1", bcd_out, load_err);
        end
        load_val = 8'h60;
        tick();
        vecs++;
        if (bcd_out !== 8'h45 || load_err !== 1'b1) begin
            errs++;
            $display("FAIL load_60: got %h e=%b, want 45 1", bcd_out, load_err);
        end
        load = 1'b0;
        tick();
        vecs++;
        if (load_err !== 1'b0) begin
            errs++;
            $display("FAIL load_err_pulse: got %b, want 0", load_err);
        end
        load = 1'b1;
        en = 1'b1;
        up = 1'b1;
        load_val = 8'h59;
        tick();
        vecs++;
        if (bcd_out !== 8'h59 || carry !== 1'b0 || load_err !== 1'b0) begin
            errs++;
            $display("FAIL load_over_en: got %h c=%b e=%b, want 59 0 0", bcd_out, carry, load_err);
        end
        load = 1'b0;
        en = 1'b0;
`else
        load = 1'b1;
        load_val = 8'h45;
        tick();
        load = 1'b0;
        vecs++;
        if (bcd_out !== 8'h00 || load_err !== 1'b0) begin
            errs++;
            $display("FAIL load_ignored: got %h e=%b, want 00 0", bcd_out, load_err);
        end
`endif
    endtask

    task automatic test_four_digit();
        int carries;
        carries = 0;
        do_clear();
        en4 = 1'b1;
        for (int i = 0; i < 9999; i++) begin
            tick();
            if (carry4 === 1'b1) carries++;
        end
        vecs++;
        if (d4_out !== 16'h9999 || carries != 0) begin
            errs++;
            $display("FAIL d4_at_9999: got %h carries=%0d, want 9999 0", d4_out, carries);
        end
        tick();
        vecs++;
        if (d4_out !== 16'h0000 || carry4 !== 1'b1) begin
            errs++;
            $display("FAIL d4_wrap: got %h c=%b, want 0000 1", d4_out, carry4);
        end
        tick();
        vecs++;
        if (d4_out !== 16'h0001 || carry4 !== 1'b0) begin
            errs++;
            $display("FAIL d4_no_stretch: got %h c=%b, want 0001 0", d4_out, carry4);
        end
        en4 = 1'b0;
    endtask

    task automatic test_chain();
        int pulses;
        pulses = 0;
        do_clear();
        en_c = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (lo_carry === 1'b1) pulses++;
        end
        en_c = 1'b0;
        vecs++;
        if (lo_out !== 4'h5 || hi_out !== 8'h02 || pulses != 2) begin
            errs++;
            $display("FAIL chain: got lo=%h hi=%h pulses=%0d, want 5 02 2", lo_out, hi_out, pulses);
        end
    endtask

    initial begin
        vecs        = 0;
        errs        = 0;
        rst_n       = 1'b0;
        en          = 1'b0;
        clr         = 1'b0;
        up          = 1'b1;
        load        = 1'b0;
        load_val    = 8'h00;
        en4         = 1'b0;
        load_val4   = 16'h0000;
        en_c        = 1'b0;
        one_up      = 1'b1;
        no_load     = 1'b0;
        load_val_lo = 4'h0;
        load_val_hi = 8'h00;

        test_reset();
        test_count_up();
        test_ripple();
        test_down_wrap();
        test_simultaneous();
        test_load();
        test_four_digit();
        test_chain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
